// File: rtl/mor1kx_timer_array.sv
// Multi-channel tick timer: NUM_TIMERS independent TTMR/TTCR pairs on the SPR bus.
// Optional shared prescaler is built when OR1K_TIMER_PRESCALER_EN is defined.
module mor1kx_timer_array #(
  parameter int NUM_TIMERS   = 2,
  parameter int PERIOD_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spr_access_i,
  input  logic                  spr_we_i,
  input  logic [15:0]           spr_addr_i,
  input  logic [31:0]           spr_dat_i,
  output logic                  spr_bus_ack,
  output logic [31:0]           spr_dat_o,
  output logic [NUM_TIMERS-1:0] irq_o,
  output logic                  tick_o
);

  // Keeps mode/IE/IP and the implemented period bits; bits PERIOD_WIDTH..27 stay 0.
  function automatic logic [31:0] ttmr_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i >= 28) || (i < PERIOD_WIDTH);
    end
    return m;
  endfunction

  localparam logic [31:0] TTMR_MASK = ttmr_mask();

  logic [10:0]                  offset;
  logic                         we;
  logic                         tick;
  logic [31:0]                  ps_rd;
  logic [NUM_TIMERS-1:0][31:0]  chan_rd;
  logic                         unused_addr;

  assign offset      = spr_addr_i[10:0];
  assign unused_addr = ^spr_addr_i[15:11];
  assign we          = spr_access_i & spr_we_i;
  assign spr_bus_ack = spr_access_i;
  assign tick_o      = tick;

`ifdef OR1K_TIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] divider;
  logic        ps_sel;

  assign ps_sel = spr_access_i && (offset == 11'd16);
  assign tick   = (divider == prescale);
  assign ps_rd  = ps_sel ? {16'h0000, prescale} : 32'h0000_0000;

  // Prescale register and free-running divider; a PRESCALE write restarts the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= 16'h0000;
      divider  <= 16'h0000;
    end else if (we && ps_sel) begin
      prescale <= spr_dat_i[15:0];
      divider  <= 16'h0000;
    end else if (tick) begin
      divider  <= 16'h0000;
    end else begin
      divider  <= divider + 16'd1;
    end
  end
`else
  assign tick  = 1'b1;
  assign ps_rd = 32'h0000_0000;
`endif

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
    logic [31:0] ttmr;
    logic [31:0] ttcr;
    logic [1:0]  mode;
    logic        mr_sel;
    logic        cr_sel;
    logic        match;

    assign mr_sel = spr_access_i && (offset == 11'(2 * n));
    assign cr_sel = spr_access_i && (offset == 11'(2 * n + 1));
    assign mode   = ttmr[31:30];
    assign match  = (ttcr[PERIOD_WIDTH-1:0] == ttmr[PERIOD_WIDTH-1:0]);

    // Per-channel state; the comparison sets IP regardless of mode.
    always_ff @(posedge clk) begin
      if (rst) begin
        ttmr <= 32'h0000_0000;
        ttcr <= 32'h0000_0000;
      end else begin
        if (we && mr_sel) begin
          ttmr <= spr_dat_i & TTMR_MASK;
        end else if (match && ttmr[29]) begin
          ttmr[28] <= 1'b1;
        end else begin
          ttmr <= ttmr;
        end

        if (we && cr_sel) begin
          ttcr <= spr_dat_i;
        end else if ((mode == 2'b01) && match && tick) begin
          ttcr <= 32'h0000_0000;
        end else if (tick && (((mode != 2'b00) && !match) || (mode == 2'b11))) begin
          ttcr <= ttcr + 32'd1;
        end else begin
          ttcr <= ttcr;
        end
      end
    end

    assign irq_o[n]   = ttmr[28] & ttmr[29];
    assign chan_rd[n] = ({32{mr_sel}} & ttmr) | ({32{cr_sel}} & ttcr);
  end

  // Selects are one-hot (or all zero), so the read mux is a plain OR.
  always_comb begin
    spr_dat_o = ps_rd;
    for (int n = 0; n < NUM_TIMERS; n++) begin
      spr_dat_o = spr_dat_o | chan_rd[n];
    end
  end

endmodule

// File: tb/tb_mor1kx_timer_array.sv
// Directed bench for mor1kx_timer_array; expected values are hand-derived from the timer rules.
module tb_mor1kx_timer_array;

  logic        clk;
  logic        rst;
  logic        spr_access;
  logic        spr_we;
  logic [15:0] spr_addr;
  logic [31:0] spr_dat;
  logic        spr_bus_ack;
  logic [31:0] spr_dat_o;
  logic [1:0]  irq;
  logic        tick;

  int checks = 0;
  int errors = 0;

  mor1kx_timer_array #(.NUM_TIMERS(2), .PERIOD_WIDTH(28)) dut (
    .clk          (clk),
    .rst          (rst),
    .spr_access_i (spr_access),
    .spr_we_i     (spr_we),
    .spr_addr_i   (spr_addr),
    .spr_dat_i    (spr_dat),
    .spr_bus_ack  (spr_bus_ack),
    .spr_dat_o    (spr_dat_o),
    .irq_o        (irq),
    .tick_o       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] off, input logic [31:0] d);
    spr_access = 1'b1;
    spr_we     = 1'b1;
    spr_addr   = {5'b01010, off};
    spr_dat    = d;
    step();
    spr_access = 1'b0;
    spr_we     = 1'b0;
    spr_dat    = 32'h0;
  endtask

  task automatic chk_rd(input string tag, input logic [10:0] off, input logic [31:0] exp);
    spr_access = 1'b1;
    spr_we     = 1'b0;
    spr_addr   = {5'b01010, off};
    #1;
    check(tag, spr_dat_o, exp);
    spr_access = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spr_access = 1'b0; spr_we = 1'b0; spr_addr = 16'h0; spr_dat = 32'h0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk_rd("rst_ttmr0", 11'd0, 32'h0);
    chk_rd("rst_ttcr0", 11'd1, 32'h0);
    chk_rd("rst_ttmr1", 11'd2, 32'h0);
    step();
    chk_rd("rst_ttcr1", 11'd3, 32'h0);
    chk_rd("rst_ps", 11'd16, 32'h0);
    check("rst_irq", {30'h0, irq}, 32'h0);
    check("rst_tick", {31'h0, tick}, 32'h1);
    spr_access = 1'b1; #1;
    check("ack_hi", {31'h0, spr_bus_ack}, 32'h1);
    spr_access = 1'b0; #1;
    check("ack_lo", {31'h0, spr_bus_ack}, 32'h0);

    // Ch0 mode 01 period 5 with IE: 0..5 then back to 0, IP one cycle after 5
    wr(11'd0, 32'h6000_0005);
    for (int k = 0; k < 6; k++) begin
      chk_rd($sformatf("m01_ttcr_%0d", k), 11'd1, 32'(k));
      check($sformatf("m01_irq_%0d", k), {30'h0, irq}, 32'h0);
      step();
    end
    chk_rd("m01_wrap", 11'd1, 32'h0);
    check("m01_irq_set", {30'h0, irq}, 32'h1);
    for (int k = 0; k < 5; k++) step();
    chk_rd("m01_ttcr_5b", 11'd1, 32'h5);
    chk_rd("m01_ttmr_ip", 11'd0, 32'h7000_0005);
    // TTMR write in the match cycle: write wins, IP cleared, counter still restarts
    wr(11'd0, 32'h6000_0005);
    check("ipclr_irq", {30'h0, irq}, 32'h0);
    chk_rd("ipclr_ttcr", 11'd1, 32'h0);
    step();
    chk_rd("ipclr_ttcr1", 11'd1, 32'h1);
    check("ipclr_irq1", {30'h0, irq}, 32'h0);

    // Ch1 mode 10 period 3 (no IE), ch0 mode 11 period 2
    wr(11'd2, 32'h8000_0003);
    wr(11'd1, 32'h0);
    wr(11'd0, 32'hC000_0002);
    chk_rd("m10_c0_a", 11'd1, 32'h1);
    chk_rd("m10_c1_a", 11'd3, 32'h2);
    step();
    chk_rd("m10_c0_b", 11'd1, 32'h2);
    chk_rd("m10_c1_b", 11'd3, 32'h3);
    step();
    chk_rd("m11_pass", 11'd1, 32'h3);
    chk_rd("m10_freeze", 11'd3, 32'h3);
    step();
    chk_rd("m11_c0_c", 11'd1, 32'h4);
    chk_rd("m10_freeze2", 11'd3, 32'h3);
    check("m10_irq", {30'h0, irq}, 32'h0);
    chk_rd("m10_ttmr1", 11'd2, 32'h8000_0003);

    // Unmapped offsets ignore writes and read 0 (prescaler absent in default build)
    wr(11'd5, 32'hDEAD_BEEF);
    chk_rd("unmap5", 11'd5, 32'h0);
    chk_rd("unmap_c1", 11'd3, 32'h3);
`ifndef OR1K_TIMER_PRESCALER_EN
    wr(11'd16, 32'h0000_0003);
    chk_rd("noprescale", 11'd16, 32'h0);
    check("tick_const", {31'h0, tick}, 32'h1);
`endif

    // 32-bit wrap with mode 11 period 0 and IE
    wr(11'd1, 32'hFFFF_FFFE);
    wr(11'd0, 32'hE000_0000);
    chk_rd("wrap_ff", 11'd1, 32'hFFFF_FFFF);
    check("wrap_irq0", {30'h0, irq}, 32'h0);
    step();
    chk_rd("wrap_0", 11'd1, 32'h0);
    check("wrap_irq1", {30'h0, irq}, 32'h0);
    step();
    chk_rd("wrap_1", 11'd1, 32'h1);
    check("wrap_irq2", {30'h0, irq}, 32'h1);

    // TTCR write during match: written value loads, IP still sets
    wr(11'd0, 32'h6000_0003);
    chk_rd("cw_pre", 11'd1, 32'h2);
    step();
    chk_rd("cw_match", 11'd1, 32'h3);
    wr(11'd1, 32'h0000_0010);
    chk_rd("cw_loaded", 11'd1, 32'h10);
    check("cw_irq", {30'h0, irq}, 32'h1);
    step();
    chk_rd("cw_next", 11'd1, 32'h11);

    // Reset mid-count overrides a simultaneous write
    spr_access = 1'b1; spr_we = 1'b1; spr_addr = 16'h5001; spr_dat = 32'h1234; rst = 1'b1;
    step();
    rst = 1'b0; spr_access = 1'b0; spr_we = 1'b0;
    chk_rd("rstmid_ttcr0", 11'd1, 32'h0);
    chk_rd("rstmid_ttmr0", 11'd0, 32'h0);
    chk_rd("rstmid_ttcr1", 11'd3, 32'h0);
    check("rstmid_irq", {30'h0, irq}, 32'h0);

`ifdef OR1K_TIMER_PRESCALER_EN
    // PRESCALE=3: one tick every 4 cycles; rewriting restarts the phase
    wr(11'd0, 32'hC000_00FF);
    wr(11'd16, 32'h0000_0003);
    chk_rd("ps_reg", 11'd16, 32'h3);
    chk_rd("ps_c0", 11'd1, 32'h1);
    check("ps_t0", {31'h0, tick}, 32'h0);
    step(); check("ps_t1", {31'h0, tick}, 32'h0);
    step(); check("ps_t2", {31'h0, tick}, 32'h0);
    step(); check("ps_t3", {31'h0, tick}, 32'h1);
    chk_rd("ps_c0_hold", 11'd1, 32'h1);
    step(); check("ps_t4", {31'h0, tick}, 32'h0);
    chk_rd("ps_c0_inc", 11'd1, 32'h2);
    step(); step();
    wr(11'd16, 32'h0000_0003);
    check("ps_rw0", {31'h0, tick}, 32'h0);
    step(); step();
    check("ps_rw2", {31'h0, tick}, 32'h0);
    step();
    check("ps_rw3", {31'h0, tick}, 32'h1);
    chk_rd("ps_c0_rw", 11'd1, 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mor1kx_timer_array.md
# mor1kx_timer_array

Multi-channel tick timer unit for the mor1kx control path. It generalises the single tick timer to NUM_TIMERS independent channels, each with its own mode/match register (TTMR) and count register (TTCR) on the SPR bus. Channels have a configurable period-field width and a per-channel interrupt line. An optional shared prescaler sits in front of all channels.

## Interface
- NUM_TIMERS, 2: channel count, 1..8.
- PERIOD_WIDTH, 28: TTMR period field width and TTCR compare width, 1..28.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- spr_access_i  input  1  SPR access strobe for this unit's group.
- spr_we_i  input  1  SPR write qualifier.
- spr_addr_i  input  16  SPR address; offset = spr_addr_i[10:0].
- spr_dat_i  input  32  SPR write data.
- spr_bus_ack  output  1  equals spr_access_i, same cycle.
- spr_dat_o  output  32  read data, combinational.
- irq_o  output  NUM_TIMERS  per-channel interrupt, bit n = TTMR[n][28] & TTMR[n][29].
- tick_o  output  1  prescaler tick; constant 1 when prescaler is compiled out.

## Operation
- Address map: channel n TTMR at offset 2n, TTCR at offset 2n+1. PRESCALE at offset 16. Other offsets read 0 and ignore writes.
- TTMR layout:
  - [31:30] mode: 00 disabled, 01 restart on match, 10 stop on match, 11 continuous.
  - [29] IE. [28] IP.
  - [PERIOD_WIDTH-1:0] period. Bits PERIOD_WIDTH..27 read 0.
- TTCR is 32-bit. match[n] = TTCR[n][PERIOD_WIDTH-1:0] == TTMR[n][PERIOD_WIDTH-1:0].
- Per channel, per cycle, TTCR update in priority order:
  - SPR write to TTCR: load spr_dat_i.
  - mode 01 & match & tick: load 0.
  - tick & ((mode != 00 & !match) | mode == 11): increment by 1; wraps 0xFFFFFFFF -> 0.
  - otherwise hold.
- Per channel TTMR update, priority order:
  - SPR write to TTMR: load spr_dat_i, upper unused period bits forced 0. Writing IP=0 clears a pending interrupt.
  - match & IE: set IP.
- IP is level/sticky. It stays set until software writes it to 0. Match in mode 00 still sets IP if IE=1, since the comparison is independent of mode.
- Channels are fully independent. A write to one channel never affects another.
- Read mux: TTMR/TTCR/PRESCALE of the addressed offset when spr_access_i, else 0.

## Timing
- Reset values: all TTMR = 0, all TTCR = 0, PRESCALE = 0, prescaler divider = 0, irq_o = 0, tick_o = 1 (prescale 0 means tick every cycle). spr_dat_o and spr_bus_ack follow inputs.
- SPR ack and read data are zero-latency. A written value is visible on reads from the next cycle.
- Counter increments on the first tick cycle after the mode register becomes non-zero.
- IP sets one cycle after TTCR reaches the period value. irq_o follows IP with no extra delay.
- Mode 01: sequence period-1, period, 0, 1. The counter holds the period value for exactly one tick.
- Mode 10: the counter freezes at the period value until software rewrites TTCR or TTMR.
- Simultaneous SPR write and match on the same register: the write wins, and the same-cycle IP set is lost.
- rst asserted mid-count returns every register to its reset value on the next edge, overriding writes.

## Configuration
- OR1K_TIMER_PRESCALER_EN defined:
  - 16-bit PRESCALE register at offset 16, plus a 16-bit divider counter.
  - tick_o = (divider == PRESCALE).
  - Divider increments every cycle and reloads 0 on tick.
  - Writing PRESCALE loads the value and zeroes the divider.
  - Channels count once per PRESCALE+1 cycles. Match detection and IP set still occur every cycle.
- Undefined: no PRESCALE register. Offset 16 reads 0 and ignores writes. tick_o = 1 and all channels count every cycle.

## Test plan
- Reset, then read offsets 0..3 and 16 -> all 0. irq_o = 0.
- Ch0: TTMR = 0x6000_0005 (mode 01, IE). Run 20 cycles -> TTCR cycles 0..5,0..; irq_o[0] rises one cycle after TTCR=5. Write TTMR IP=0 -> irq_o[0] drops next cycle.
- Ch1: TTMR = 0x8000_0003 (mode 10). Ch0: mode 11, period 2. -> ch1 freezes at 3 with irq_o[1]=0 (IE off). Ch0 passes 2 and keeps counting.
- Ch0: TTCR = 0xFFFF_FFFE, mode 11, period 0 -> counts FFFFFFFF, 0 (match, IP set if IE), 1.
- Same-cycle TTCR write and match on ch0 -> written value loaded, no clear.
- With OR1K_TIMER_PRESCALER_EN: PRESCALE = 3, ch0 mode 11 -> TTCR increments every 4th cycle and tick_o pulses every 4 cycles. Rewriting PRESCALE restarts the divider phase.
